roba_approx_divider: RTL
========================

// Module: roba_approx_divider
// PURPOSE
//  Sequential signed approximate divider; the inverse operator to the rounding-based approximate multiplier.
//  Each operand magnitude is truncated to its TRUNC_BITS most-significant bits starting at the leading one.
//  The truncated magnitudes are divided exactly by a bit-serial restoring divider.
//  The quotient is then rescaled by the difference of the truncation shifts and re-signed.
//  Valid/ready on both sides; one division in flight; sits alongside the multiplier in the PDA datapath.
// PARAMETERS
//  DATA_W      32  operand and quotient width (two's complement)
//  TRUNC_BITS  8   significant bits kept per operand; legal 2..DATA_W; also the number of divide iterations
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        operands valid
//  in_ready     out  1        block can accept operands
//  dividend     in   DATA_W   signed x
//  divisor      in   DATA_W   signed y
//  out_valid    out  1        result valid; held until accepted
//  out_ready    in   1        consumer accepts result
//  quotient     out  DATA_W   signed approximate x/y
//  div_by_zero  out  1        qualifies quotient when y==0
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; out_valid=0; quotient=0; div_by_zero=0.
//  Reset asserted mid-operation discards that operation.
//  FSM: IDLE -> NORM -> DIV -> FIX -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready, register x and y and go to NORM. in_ready=0 in every other state.
//  NORM (1 cycle):
//   a=|x|, b=|y| as DATA_W-bit unsigned magnitudes; -2^(DATA_W-1) gives magnitude 2^(DATA_W-1).
//   la, lb = leading-one positions of a, b.
//   sa = max(la-TRUNC_BITS+1, 0); at = a>>sa. Same rule gives sb and bt. a==0 gives sa=0, at=0.
//   sign = x[MSB]^y[MSB].
//   If b==0: skip DIV and go straight to FIX.
//  DIV: exactly TRUNC_BITS cycles of restoring division, one quotient bit per cycle, MSB first.
//   Result is qt = floor(at/bt), TRUNC_BITS wide.
//  FIX (1 cycle):
//   d = sa-sb (signed).
//   mag = qt<<d if d>=0, else qt>>(-d). Compute mag in 2*DATA_W bits; no bits may be lost before the saturation check.
//   If sign=0 and mag > 2^(DATA_W-1)-1: quotient = 0x7FFF_FFFF.
//   If sign=1 and mag > 2^(DATA_W-1): quotient = 0x8000_0000.
//   Otherwise quotient = sign ? -mag : mag. mag==0 always gives quotient=0.
//   Divide by zero: div_by_zero=1; quotient = 0x7FFF_FFFF if x>=0, else 0x8000_0000.
//   Otherwise div_by_zero=0.
//  DONE: out_valid=1; quotient and div_by_zero are stable while out_valid&!out_ready.
//   On out_valid&out_ready go to IDLE; out_valid=0 next cycle.
//  Latency: out_valid rises TRUNC_BITS+2 edges after the accepting edge (2 edges for divide by zero).
//   Next accept is possible 1 cycle after the result handshake; no combinational in->out path.
//  Rounding: truncation toward zero on magnitudes. TRUNC_BITS=DATA_W gives exact C-style division, apart from the saturation case.
//  Inputs are sampled only at the accepting edge; later changes are ignored.
// TESTING (TRUNC_BITS=8 unless noted)
//  x=100, y=7 -> quotient=14, div_by_zero=0; out_valid rises 10 edges after accept.
//  x=1000, y=3 -> sa=2, at=250, qt=83 -> quotient=332 (approximation; exact value is 333).
//  x=-100, y=7 -> quotient=0xFFFF_FFF2 (-14); x=-100, y=-7 -> quotient=14.
//  x=0x8000_0000, y=-1 -> mag=2^31, sign=0 -> quotient=0x7FFF_FFFF.
//  x=-5, y=0 -> quotient=0x8000_0000 and div_by_zero=1 after 2 edges; x=0, y=0 -> quotient=0x7FFF_FFFF.
//  Hold out_ready=0 for 5 cycles: out_valid and quotient stable, in_ready=0.
//  rst_n pulsed low mid-DIV: outputs return to reset values at once; the next op (x=9, y=3) gives 3.

Source files
------------

// File: rtl/roba_approx_divider_if.sv
// Handshake bundle for the approximate divider.
//   in_valid / in_ready   : operand transfer (dividend, divisor)
//   out_valid / out_ready : result transfer (quotient, div_by_zero)
// master drives operands and accepts results; slave is the divider.
interface roba_approx_divider_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] quotient;
  logic              div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, div_by_zero
  );
endinterface

// File: rtl/roba_approx_divider.sv
// Sequential signed approximate divider, the inverse of the rounding-based
// approximate multiplier. Each operand magnitude is cut to its TRUNC_BITS
// most significant bits (from the leading one), the truncated values are
// divided exactly by a bit-serial restoring divider, and the quotient is
// rescaled by the difference of the two truncation shifts, re-signed and
// saturated. One division in flight.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of roba_approx_divider_if:
//          in_valid/in_ready/dividend/divisor      operand handshake
//          out_valid/out_ready/quotient/div_by_zero result handshake
module roba_approx_divider #(
  parameter int DATA_W     = 32,
  parameter int TRUNC_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  roba_approx_divider_if.slave  bus
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(TRUNC_BITS + 1);
  localparam int MAG_W = 2 * DATA_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  state_t state;
  logic [CNT_W-1:0] cnt;

  // Operands captured at the accepting edge
  logic signed [DATA_W-1:0] x_p0;
  logic signed [DATA_W-1:0] y_p0;

  // Normalised operands
  logic [TRUNC_BITS-1:0] bt_p1;
  logic [SH_W-1:0]       sa_p1;
  logic [SH_W-1:0]       sb_p1;
  logic                  sign_p1;
  logic                  bzero_p1;
  logic                  xneg_p1;

  // Restoring divider: qt_p2 starts holding the truncated dividend and
  // shifts quotient bits in from the LSB as dividend bits leave the MSB.
  logic [TRUNC_BITS:0]   rem_p2;
  logic [TRUNC_BITS-1:0] qt_p2;

  // Absolute value as an unsigned magnitude; the most negative value maps
  // onto 2^(DATA_W-1), which is representable unsigned.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return v[DATA_W-1] ? (~u + 1'b1) : u;
  endfunction

  // Right shift that leaves TRUNC_BITS significant bits; zero for small or
  // zero magnitudes.
  function automatic logic [SH_W-1:0] trunc_shift(input logic [DATA_W-1:0] m);
    int lo;
    lo = 0;
    for (int i = 0; i < DATA_W; i++) begin
      if (m[i]) lo = i;
    end
    if (lo >= TRUNC_BITS) return SH_W'(lo - TRUNC_BITS + 1);
    return '0;
  endfunction

  // Clamp the rescaled magnitude to the signed range and apply the sign.
  function automatic logic [DATA_W-1:0] saturate(input logic [MAG_W-1:0] m, input logic neg);
    logic [MAG_W-1:0]  pos_lim;
    logic [MAG_W-1:0]  neg_lim;
    logic [DATA_W-1:0] m_lo;
    pos_lim = {{(MAG_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    neg_lim = pos_lim + 1'b1;
    m_lo    = m[DATA_W-1:0];
    if (!neg && (m > pos_lim)) return {1'b0, {(DATA_W-1){1'b1}}};
    if (neg && (m > neg_lim))  return {1'b1, {(DATA_W-1){1'b0}}};
    return neg ? (~m_lo + 1'b1) : m_lo;
  endfunction

  logic [DATA_W-1:0]       a_c;
  logic [DATA_W-1:0]       b_c;
  logic [SH_W-1:0]         sa_c;
  logic [SH_W-1:0]         sb_c;
  logic [TRUNC_BITS:0]     rem_trial;
  logic                    q_bit;
  logic [TRUNC_BITS:0]     rem_next;
  logic signed [SH_W:0]    d_c;
  logic [SH_W:0]           d_abs;
  logic [MAG_W-1:0]        q_ext;
  logic [MAG_W-1:0]        mag_c;
  logic [DATA_W-1:0]       quot_c;

  always_comb begin
    a_c  = magnitude(x_p0);
    b_c  = magnitude(y_p0);
    sa_c = trunc_shift(a_c);
    sb_c = trunc_shift(b_c);

    rem_trial = {rem_p2[TRUNC_BITS-1:0], qt_p2[TRUNC_BITS-1]};
    q_bit     = (rem_trial >= {1'b0, bt_p1});
    rem_next  = q_bit ? (rem_trial - {1'b0, bt_p1}) : rem_trial;

    d_c   = $signed({1'b0, sa_p1}) - $signed({1'b0, sb_p1});
    d_abs = d_c[SH_W] ? $unsigned(-d_c) : $unsigned(d_c);
    q_ext = MAG_W'(qt_p2);
    mag_c = d_c[SH_W] ? (q_ext >> d_abs) : (q_ext << d_abs);

    if (bzero_p1) quot_c = xneg_p1 ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else          quot_c = saturate(mag_c, sign_p1);
  end

  // Control and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      cnt             <= '0;
      bus.in_ready    <= 1'b1;
      bus.out_valid   <= 1'b0;
      bus.quotient    <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            bus.in_ready <= 1'b0;
            state        <= S_NORM;
          end
        end
        S_NORM: begin
          cnt   <= CNT_W'(TRUNC_BITS - 1);
          state <= (b_c == '0) ? S_FIX : S_DIV;
        end
        S_DIV: begin
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          bus.quotient    <= quot_c;
          bus.div_by_zero <= bzero_p1;
          bus.out_valid   <= 1'b1;
          state           <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    case (state)
      // capture: p0
      S_IDLE: begin
        if (bus.in_valid) begin
          x_p0 <= bus.dividend;
          y_p0 <= bus.divisor;
        end
      end
      // normalise: p0 -> p1, seed divider p2
      S_NORM: begin
        bt_p1    <= TRUNC_BITS'(b_c >> sb_c);
        sa_p1    <= sa_c;
        sb_p1    <= sb_c;
        sign_p1  <= x_p0[DATA_W-1] ^ y_p0[DATA_W-1];
        bzero_p1 <= (b_c == '0);
        xneg_p1  <= x_p0[DATA_W-1];
        qt_p2    <= TRUNC_BITS'(a_c >> sa_c);
        rem_p2   <= '0;
      end
      // divide: one quotient bit per cycle into p2
      S_DIV: begin
        rem_p2 <= rem_next;
        qt_p2  <= {qt_p2[TRUNC_BITS-2:0], q_bit};
      end
      default: ;
    endcase
  end

endmodule
